// File: rtl/dmem_arbiter_pkg.sv
// Shared core pipeline definitions for the data-memory arbiter:
// FSM state encoding, default MMU timeout and the latched request bundle.
package dmem_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2,
    ST_RESP = 2'd3
  } dmem_state_e;

  localparam int DMEM_TIMEOUT = 255;

  typedef struct packed {
    logic        owner;
    logic [31:0] addr;
    logic [3:0]  strb;
    logic [31:0] wdata;
  } dmem_txn_t;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Data-side MMU bus: split read request/response and write request/ack.
// master = arbiter side, slave = MMU side.
interface dmem_arbiter_if;

  logic        DATA_RDEN;
  logic [31:0] DATA_RIADDR;
  logic [31:0] DATA_ROADDR;
  logic        DATA_RVALID;
  logic [31:0] DATA_RDATA;
  logic        DATA_WREN;
  logic [31:0] DATA_WADDR;
  logic [3:0]  DATA_WSTRB;
  logic [31:0] DATA_WDATA;
  logic        DATA_WDONE;

  modport master (
    output DATA_RDEN, DATA_RIADDR,
    output DATA_WREN, DATA_WADDR,
    output DATA_WSTRB, DATA_WDATA,
    input  DATA_ROADDR, DATA_RVALID,
    input  DATA_RDATA, DATA_WDONE
  );

  modport slave (
    input  DATA_RDEN, DATA_RIADDR,
    input  DATA_WREN, DATA_WADDR,
    input  DATA_WSTRB, DATA_WDATA,
    output DATA_ROADDR, DATA_RVALID,
    output DATA_RDATA, DATA_WDONE
  );

endinterface

// File: rtl/dmem_arbiter.sv
// Two-requester data-memory arbiter: one MMU transaction at a time,
// round-robin grant, timeout abort and flush-drop for requester 0.
// Ports: CLK/RST, FLUSH, REQ0_*/REQ1_* requester side, mmu bus master.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int TIMEOUT = DMEM_TIMEOUT
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        FLUSH,
  input  logic        REQ0_VALID,
  input  logic        REQ0_WE,
  input  logic [31:0] REQ0_ADDR,
  input  logic [3:0]  REQ0_STRB,
  input  logic [31:0] REQ0_WDATA,
  output logic        REQ0_WAIT,
  output logic        REQ0_DONE,
  output logic [31:0] REQ0_RDATA,
  output logic        REQ0_ERR,
  input  logic        REQ1_VALID,
  input  logic        REQ1_WE,
  input  logic [31:0] REQ1_ADDR,
  input  logic [3:0]  REQ1_STRB,
  input  logic [31:0] REQ1_WDATA,
  output logic        REQ1_WAIT,
  output logic        REQ1_DONE,
  output logic [31:0] REQ1_RDATA,
  output logic        REQ1_ERR,
  dmem_arbiter_if.master mmu
);

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  dmem_state_e state_q, state_d;
  dmem_txn_t   txn_q, txn_d;
  logic        last_q, last_d;
  logic        drop_q, drop_d;
  logic        err_q, err_d;
  logic [31:0] rdata_q, rdata_d;
  logic [7:0]  cnt_q, cnt_d;

  logic req0_ok;
  logic pick1;
  logic rd_hit;
  logic expired;
  logic in_rd;
  logic in_wr;
  logic resp_ok;

  always_comb begin
    state_d = state_q;
    txn_d   = txn_q;
    last_d  = last_q;
    drop_d  = drop_q;
    err_d   = err_q;
    rdata_d = rdata_q;
    cnt_d   = cnt_q;

    // flush masks requester 0 at the grant point only
    req0_ok = REQ0_VALID & ~FLUSH;
    // last_q holds the previous owner; the other one wins a tie
    pick1   = REQ1_VALID & (~req0_ok | ~last_q);
    rd_hit  = mmu.DATA_RVALID
            & (mmu.DATA_ROADDR == txn_q.addr);
    expired = (cnt_q == CNT_LAST);

    unique case (state_q)
      ST_IDLE: begin
        if (req0_ok | REQ1_VALID) begin
          txn_d.owner = pick1;
          txn_d.addr  = pick1 ? REQ1_ADDR : REQ0_ADDR;
          txn_d.strb  = pick1 ? REQ1_STRB : REQ0_STRB;
          txn_d.wdata = pick1 ? REQ1_WDATA : REQ0_WDATA;
          last_d  = pick1;
          drop_d  = 1'b0;
          err_d   = 1'b0;
          rdata_d = '0;
          cnt_d   = '0;
          if (pick1 ? REQ1_WE : REQ0_WE) begin
            state_d = ST_WR;
          end else begin
            state_d = ST_RD;
          end
        end
      end
      ST_RD: begin
        cnt_d = cnt_q + 8'd1;
        if (FLUSH & ~txn_q.owner) begin
          drop_d = 1'b1;
        end
        if (rd_hit) begin
          rdata_d = mmu.DATA_RDATA;
          state_d = ST_RESP;
        end else if (expired) begin
          err_d   = 1'b1;
          state_d = ST_RESP;
        end
      end
      ST_WR: begin
        cnt_d = cnt_q + 8'd1;
        if (FLUSH & ~txn_q.owner) begin
          drop_d = 1'b1;
        end
        if (mmu.DATA_WDONE) begin
          state_d = ST_RESP;
        end else if (expired) begin
          err_d   = 1'b1;
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_IDLE;
      txn_q   <= '0;
      last_q  <= 1'b1;
      drop_q  <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      txn_q   <= txn_d;
      last_q  <= last_d;
      drop_q  <= drop_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
      cnt_q   <= cnt_d;
    end
  end

  // RST gates every output so the block is quiet from the
  // first reset cycle, before the state register settles
  assign in_rd   = ~RST & (state_q == ST_RD);
  assign in_wr   = ~RST & (state_q == ST_WR);
  assign resp_ok = ~RST & (state_q == ST_RESP) & ~drop_q;

  assign REQ0_DONE  = resp_ok & ~txn_q.owner;
  assign REQ1_DONE  = resp_ok & txn_q.owner;
  assign REQ0_WAIT  = ~RST & REQ0_VALID & ~REQ0_DONE;
  assign REQ1_WAIT  = ~RST & REQ1_VALID & ~REQ1_DONE;
  assign REQ0_RDATA = REQ0_DONE ? rdata_q : '0;
  assign REQ1_RDATA = REQ1_DONE ? rdata_q : '0;
  assign REQ0_ERR   = REQ0_DONE & err_q;
  assign REQ1_ERR   = REQ1_DONE & err_q;

  assign mmu.DATA_RDEN   = in_rd;
  assign mmu.DATA_RIADDR = in_rd ? txn_q.addr : '0;
  assign mmu.DATA_WREN   = in_wr;
  assign mmu.DATA_WADDR  = in_wr ? txn_q.addr : '0;
  assign mmu.DATA_WSTRB  = in_wr ? txn_q.strb : '0;
  assign mmu.DATA_WDATA  = in_wr ? txn_q.wdata : '0;

endmodule
